// File: rtl/clk_strobe_gen_pkg.sv
// Shared types and constants for the multi-channel strobe generator.
// Channel count width helper and config payload bundle.
package clk_strobe_pkg;

  localparam int ACC_W_DEF = 32;

  localparam logic [ACC_W_DEF-1:0] DEFAULT_INC_DEF =
    32'h8000_0000;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] inc;
    logic [ACC_W_DEF-1:0] phase;
    logic                 enable;
  } cfg_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_strobe_gen_if.sv
// Config request port: valid/ready handshake carrying one
// channel's new increment, phase and enable.
interface clk_strobe_gen_if
  import clk_strobe_pkg::*;
#(
  parameter int CH_W  = 2,
  parameter int ACC_W = ACC_W_DEF
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;
  logic             cfg_enable;

  modport master (
    output cfg_valid,
    input  cfg_ready,
    output cfg_ch,
    output cfg_inc,
    output cfg_phase,
    output cfg_enable
  );

  modport slave (
    input  cfg_valid,
    output cfg_ready,
    input  cfg_ch,
    input  cfg_inc,
    input  cfg_phase,
    input  cfg_enable
  );

endinterface

// File: rtl/clk_strobe_gen_ch.sv
// One strobe channel: phase accumulator, single-entry pending
// config slot applied on a wrap, and a strobe-count lock detector.
module clk_strobe_gen_ch
  import clk_strobe_pkg::*;
#(
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC = DEFAULT_INC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wr,
  input  cfg_t i_cfg,
  output logic o_pending,
  output logic o_stb,
  output logic o_locked
);

  localparam int LC_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_CYCLES);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic             r_en;
  logic             r_pend_v;
  cfg_t             r_pend;
  logic             r_stb;
  logic [LC_W-1:0]  r_lock_cnt;
  logic             r_locked;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_apply;
  logic             w_idle;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_carry = r_en & w_sum[ACC_W];
  // A running channel only switches on a wrap so the
  // strobe train never sees a short or long period.
  assign w_apply = r_pend_v & (w_carry | ~r_en);
  assign w_idle  = ~r_en | (r_inc == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_inc      <= DEFAULT_INC;
      r_en       <= 1'b1;
      r_pend_v   <= 1'b0;
      r_pend     <= '0;
      r_stb      <= 1'b0;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_stb <= w_carry;
      if (w_apply) begin
        r_acc    <= r_pend.phase;
        r_inc    <= r_pend.inc;
        r_en     <= r_pend.enable;
        r_pend_v <= 1'b0;
      end else begin
        if (r_en) begin
          r_acc <= w_sum[ACC_W-1:0];
        end
        if (i_wr) begin
          r_pend_v <= 1'b1;
          r_pend   <= i_cfg;
        end
      end
      if (w_apply || w_idle) begin
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end else begin
        if (w_carry && (r_lock_cnt != LC_MAX)) begin
          r_lock_cnt <= r_lock_cnt + LC_W'(1);
        end
        r_locked <= (r_lock_cnt == LC_MAX);
      end
    end
  end

  assign o_pending = r_pend_v;
  assign o_stb     = r_stb;
  assign o_locked  = r_locked;

endmodule

// File: rtl/clk_strobe_gen.sv
// Multi-channel clock-enable generator: config decode, ready
// mux and lock reduction around NUM_CH independent channels.
module clk_strobe_gen
  import clk_strobe_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC = DEFAULT_INC_DEF,
  parameter int CH_W        = ch_w(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  clk_strobe_gen_if.slave   cfg,
  output logic [NUM_CH-1:0] stb,
  output logic [NUM_CH-1:0] locked,
  output logic              locked_all
);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_busy;
  logic              w_fire;
  cfg_t              w_cfg;

  // Out-of-range channels never look busy, so such
  // requests are accepted and simply dropped.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg.cfg_ch) == i) begin
        w_busy = w_pending[i];
      end
    end
  end

  assign cfg.cfg_ready = ~rst & ~w_busy;
  assign w_fire = cfg.cfg_valid & cfg.cfg_ready;

  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i] = w_fire & (int'(cfg.cfg_ch) == i);
    end
  end

  assign w_cfg.inc    = cfg.cfg_inc;
  assign w_cfg.phase  = cfg.cfg_phase;
  assign w_cfg.enable = cfg.cfg_enable;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_strobe_gen_ch #(
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_ch (
      .clk       (refclk),
      .rst       (rst),
      .i_wr      (w_wr[g]),
      .i_cfg     (w_cfg),
      .o_pending (w_pending[g]),
      .o_stb     (stb[g]),
      .o_locked  (locked[g])
    );
  end

  assign locked_all = &locked;

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Directed bench for clk_strobe_gen: reset, rate change,
// back-to-back config, disable, zero rate, bad channel, reset.
module tb_clk_strobe_gen;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] stb;
  logic [3:0] locked;
  logic       locked_all;
  int         total = 0;
  int         bad   = 0;

  clk_strobe_gen_if #(.CH_W(3), .ACC_W(32)) cif ();

  clk_strobe_gen #(
    .NUM_CH (4),
    .CH_W   (3)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .cfg        (cif.slave),
    .stb        (stb),
    .locked     (locked),
    .locked_all (locked_all)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic idle_cfg(input int ch);
    cif.cfg_valid  = 1'b0;
    cif.cfg_ch     = 3'(ch);
    cif.cfg_inc    = '0;
    cif.cfg_phase  = '0;
    cif.cfg_enable = 1'b0;
  endtask

  task automatic req(input int ch, input logic [31:0] inc,
                     input logic [31:0] ph, input logic en);
    cif.cfg_valid  = 1'b1;
    cif.cfg_ch     = 3'(ch);
    cif.cfg_inc    = inc;
    cif.cfg_phase  = ph;
    cif.cfg_enable = en;
  endtask

  task automatic do_reset();
    idle_cfg(0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_cfg(0);
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (stb !== 4'h0) begin
      bad++;
      $display("FAIL rst_stb got=%h want=0", stb);
    end
    total++;
    if (locked !== 4'h0) begin
      bad++;
      $display("FAIL rst_locked got=%h want=0", locked);
    end
    total++;
    if (locked_all !== 1'b0) begin
      bad++;
      $display("FAIL rst_lockall got=%b want=0", locked_all);
    end
    total++;
    if (cif.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready got=%b want=0", cif.cfg_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cif.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_rst_ready got=%b want=1",
               cif.cfg_ready);
    end
  endtask

  task automatic test_run();
    logic [3:0] es;
    logic [3:0] el;
    for (int k = 1; k <= 40; k++) begin
      tick();
      es = (k % 2 == 0) ? 4'hF : 4'h0;
      el = (k >= 33) ? 4'hF : 4'h0;
      total++;
      if (stb !== es) begin
        bad++;
        $display("FAIL run_stb k=%0d got=%h want=%h", k, stb, es);
      end
      total++;
      if (locked !== el) begin
        bad++;
        $display("FAIL run_lock k=%0d got=%h want=%h",
                 k, locked, el);
      end
      total++;
      if (locked_all !== (el == 4'hF)) begin
        bad++;
        $display("FAIL run_lockall k=%0d got=%b want=%b",
                 k, locked_all, (el == 4'hF));
      end
    end
  endtask

  task automatic test_rate_change();
    logic [3:0] es;
    logic [3:0] el;
    do_reset();
    for (int k = 1; k <= 40; k++) tick();
    req(1, 32'h4000_0000, 32'h0, 1'b1);
    #1;
    total++;
    if (cif.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL rate_ready0 got=%b want=1", cif.cfg_ready);
    end
    tick();
    idle_cfg(1);
    #1;
    total++;
    if (cif.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL rate_pend_ready got=%b want=0",
               cif.cfg_ready);
    end
    tick();
    total++;
    if (stb !== 4'hF) begin
      bad++;
      $display("FAIL rate_apply_stb got=%h want=f", stb);
    end
    total++;
    if (locked !== 4'b1101) begin
      bad++;
      $display("FAIL rate_apply_lock got=%h want=d", locked);
    end
    for (int j = 1; j <= 70; j++) begin
      tick();
      es = (j % 2 == 0) ? 4'b1101 : 4'b0000;
      if (j % 4 == 0) es[1] = 1'b1;
      el = (j >= 65) ? 4'hF : 4'b1101;
      total++;
      if (stb !== es) begin
        bad++;
        $display("FAIL rate_stb j=%0d got=%h want=%h", j, stb, es);
      end
      total++;
      if (locked !== el) begin
        bad++;
        $display("FAIL rate_lock j=%0d got=%h want=%h",
                 j, locked, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e2;
    do_reset();
    req(2, 32'h4000_0000, 32'h0, 1'b1);
    tick();
    total++;
    if (cif.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stall got=%b want=0", cif.cfg_ready);
    end
    req(2, 32'h2000_0000, 32'h0, 1'b1);
    tick();
    total++;
    if (stb[2] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_apply1_stb got=%b want=1", stb[2]);
    end
    total++;
    if (cif.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready_back got=%b want=1",
               cif.cfg_ready);
    end
    tick();
    idle_cfg(2);
    #1;
    total++;
    if (cif.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_pend2 got=%b want=0", cif.cfg_ready);
    end
    for (int e = 4; e <= 22; e++) begin
      tick();
      e2 = (e == 6) || (e == 14) || (e == 22);
      total++;
      if (stb[2] !== e2) begin
        bad++;
        $display("FAIL b2b_stb2 e=%0d got=%b want=%b",
                 e, stb[2], e2);
      end
      total++;
      if (stb[0] !== (e % 2 == 0)) begin
        bad++;
        $display("FAIL b2b_stb0 e=%0d got=%b want=%b",
                 e, stb[0], (e % 2 == 0));
      end
      if (e == 6) begin
        total++;
        if (cif.cfg_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready_end got=%b want=1",
                   cif.cfg_ready);
        end
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    req(3, 32'h8000_0000, 32'h0, 1'b0);
    tick();
    idle_cfg(3);
    tick();
    total++;
    if (stb[3] !== 1'b1) begin
      bad++;
      $display("FAIL dis_last_stb got=%b want=1", stb[3]);
    end
    for (int e = 3; e <= 40; e++) begin
      tick();
      total++;
      if (stb[3] !== 1'b0) begin
        bad++;
        $display("FAIL dis_stb e=%0d got=%b want=0", e, stb[3]);
      end
    end
    total++;
    if (locked !== 4'b0111) begin
      bad++;
      $display("FAIL dis_lock got=%h want=7", locked);
    end
    total++;
    if (locked_all !== 1'b0) begin
      bad++;
      $display("FAIL dis_lockall got=%b want=0", locked_all);
    end
    req(3, 32'h8000_0000, 32'h8000_0000, 1'b1);
    tick();
    idle_cfg(3);
    #1;
    total++;
    if (cif.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL dis_pend got=%b want=0", cif.cfg_ready);
    end
    tick();
    total++;
    if (cif.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL dis_applied got=%b want=1", cif.cfg_ready);
    end
    total++;
    if (stb[3] !== 1'b0) begin
      bad++;
      $display("FAIL dis_apply_stb got=%b want=0", stb[3]);
    end
    for (int e = 43; e <= 46; e++) begin
      tick();
      total++;
      if (stb[3] !== (e % 2 == 1)) begin
        bad++;
        $display("FAIL en_stb e=%0d got=%b want=%b",
                 e, stb[3], (e % 2 == 1));
      end
    end
  endtask

  task automatic test_zero_inc();
    do_reset();
    req(0, 32'h0, 32'h0, 1'b1);
    tick();
    idle_cfg(0);
    tick();
    total++;
    if (stb[0] !== 1'b1) begin
      bad++;
      $display("FAIL zero_last_stb got=%b want=1", stb[0]);
    end
    req(0, 32'h8000_0000, 32'h0, 1'b1);
    tick();
    idle_cfg(0);
    for (int e = 1; e <= 1000; e++) begin
      tick();
      total++;
      if (stb[0] !== 1'b0) begin
        bad++;
        $display("FAIL zero_stb e=%0d got=%b want=0", e, stb[0]);
      end
      total++;
      if (cif.cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL zero_stuck e=%0d got=%b want=0",
                 e, cif.cfg_ready);
      end
    end
    total++;
    if (locked !== 4'b1110) begin
      bad++;
      $display("FAIL zero_lock got=%h want=e", locked);
    end
    total++;
    if (locked_all !== 1'b0) begin
      bad++;
      $display("FAIL zero_lockall got=%b want=0", locked_all);
    end
  endtask

  task automatic test_bad_ch_and_reset();
    logic [3:0] es;
    do_reset();
    for (int k = 1; k <= 40; k++) tick();
    req(5, 32'h4000_0000, 32'h0, 1'b0);
    #1;
    total++;
    if (cif.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL badch_ready got=%b want=1", cif.cfg_ready);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      idle_cfg(c);
      #1;
      total++;
      if (cif.cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL badch_nopend c=%0d got=%b want=1",
                 c, cif.cfg_ready);
      end
    end
    for (int e = 42; e <= 50; e++) begin
      tick();
      es = (e % 2 == 0) ? 4'hF : 4'h0;
      total++;
      if (stb !== es) begin
        bad++;
        $display("FAIL badch_stb e=%0d got=%h want=%h", e, stb, es);
      end
      total++;
      if (locked !== 4'hF) begin
        bad++;
        $display("FAIL badch_lock e=%0d got=%h want=f", e, locked);
      end
    end
    req(1, 32'h4000_0000, 32'h0, 1'b1);
    tick();
    idle_cfg(1);
    #1;
    total++;
    if (cif.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_pend got=%b want=0", cif.cfg_ready);
    end
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (stb !== 4'h0 || locked !== 4'h0) begin
      bad++;
      $display("FAIL midrst_out got=%h/%h want=0/0", stb, locked);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cif.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_clear got=%b want=1", cif.cfg_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      es = (k % 2 == 0) ? 4'hF : 4'h0;
      total++;
      if (stb !== es) begin
        bad++;
        $display("FAIL midrst_stb k=%0d got=%h want=%h",
                 k, stb, es);
      end
    end
  endtask

  initial begin
    idle_cfg(0);
    test_reset();
    test_run();
    test_rate_change();
    test_back_to_back();
    test_disable();
    test_zero_inc();
    test_bad_ch_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
